// File: rtl/stepper_cmd_player_pkg.sv
// Shared definitions for the stepper command player: command word layout,
// FSM state encoding and the default step-high width.
package stepper_cmd_player_pkg;

    localparam int CMD_W    = 32;
    localparam int DIR_BIT  = 31;
    localparam int CNT_MSB  = 30;
    localparam int CNT_LSB  = 16;
    localparam int CNT_W    = CNT_MSB - CNT_LSB + 1;
    localparam int PER_MSB  = 15;
    localparam int PER_LSB  = 0;
    localparam int PER_W    = PER_MSB - PER_LSB + 1;

    localparam int PULSE_HI_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

endpackage

// File: rtl/stepper_cmd_player_fifo.sv
// Command FIFO: power-of-two ring buffer with occupancy counter, registered
// read on pop, and a synchronous flush. Storage itself is never reset.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = rd_data_q;

    // A pop frees a slot in the same cycle, so a push while full is accepted.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
        if (do_pop)  rd_data_q     <= mem[rd_ptr_q];
    end

endmodule

// File: rtl/stepper_cmd_player.sv
// Stepper command player: queued {dir, count, period} commands are replayed
// as step pulses of fixed high width and programmable period.
module stepper_cmd_player
    import stepper_cmd_player_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PULSE_HI = PULSE_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        abort,
    output logic        step,
    output logic        dir,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        done,
    output logic        ovf
);
    localparam logic [PER_W-1:0] PH_LAST = PER_W'(PULSE_HI - 1);
    localparam logic [PER_W-1:0] LOW_OFS = PER_W'(PULSE_HI + 1);
    localparam logic [PER_W-1:0] MIN_PER = PER_W'(PULSE_HI + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PER_W-1:0]    per_q, per_d, tmr_q, tmr_d, cmd_per;
    logic                step_q, step_d, dir_q, dir_d, busy_q, busy_d;
    logic                done_q, done_d, ovf_q, ovf_d;
    logic                fifo_pop;
    logic [CMD_W-1:0]    fifo_rd_data;
    logic [$clog2(DEPTH):0] unused_count;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk     (clk),
        .clr_n   (clr_n),
        .flush   (abort),
        .push    (wr_en && !abort),
        .pop     (fifo_pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (unused_count)
    );

    assign cmd_per = fifo_rd_data[PER_MSB:PER_LSB];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        tmr_d    = tmr_q;
        dir_d    = dir_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dir_d = fifo_rd_data[DIR_BIT];
                cnt_d = fifo_rd_data[CNT_MSB:CNT_LSB];
                per_d = (cmd_per < MIN_PER) ? MIN_PER : cmd_per;
                tmr_d = '0;
                if (cnt_d == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_q == PH_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_LOW;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_LOW: begin
                // Low phase lasts (period - PULSE_HI) cycles, so tmr ends at that minus one.
                if (tmr_q == per_q - LOW_OFS) begin
                    tmr_d = '0;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            fifo_pop = 1'b0;
        end else if (wr_en && full && !fifo_pop) begin
            ovf_d = 1'b1;
        end

        step_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            tmr_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            tmr_q   <= tmr_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_stepper_cmd_player.sv
// Directed bench for stepper_cmd_player: hand-computed step timing, FIFO
// full/overflow, period clamp, abort and asynchronous reset behaviour.
module tb_stepper_cmd_player;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        abort = 1'b0;
    logic        step, dir, busy, full, empty, done, ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rise, n_done, n_high;
    int rise_t [8];
    logic prev_step;

    stepper_cmd_player #(.DEPTH(DEPTH), .PULSE_HI(2)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .abort   (abort),
        .step    (step),
        .dir     (dir),
        .busy    (busy),
        .full    (full),
        .empty   (empty),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; n_rise = 0; n_done = 0; n_high = 0; prev_step = step;
        for (int i = 0; i < 8; i++) rise_t[i] = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (step === 1'b1 && prev_step !== 1'b1) begin
            if (n_rise < 8) rise_t[n_rise] = cyc;
            n_rise++;
        end
        if (step === 1'b1) n_high++;
        if (done === 1'b1) n_done++;
        prev_step = step;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write(input logic [31:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        check("rst_step",  step,  0);
        check("rst_dir",   dir,   0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_ovf",   ovf,   0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);

        // Three steps, 2 high, 10 apart, dir=1
        clear_mon();
        write(32'h8003_000A);
        run(40);
        check("t1_rises",    n_rise, 3);
        check("t1_first",    rise_t[0], 3);
        check("t1_gap0",     rise_t[1] - rise_t[0], 10);
        check("t1_gap1",     rise_t[2] - rise_t[1], 10);
        check("t1_high_cyc", n_high, 6);
        check("t1_done",     n_done, 1);
        check("t1_dir",      dir, 1);
        check("t1_busy",     busy, 0);

        // count=0: no steps, one done, dir follows the command
        clear_mon();
        write(32'h0000_0005);
        run(8);
        check("t2_rises", n_rise, 0);
        check("t2_done",  n_done, 1);
        check("t2_dir",   dir, 0);
        check("t2_busy",  busy, 0);

        // Fill the FIFO behind a long command, then overflow
        clear_mon();
        write(32'h0001_0064);
        tick();
        for (int i = 0; i < DEPTH; i++) write(32'h0001_0005);
        check("t3_full",     full, 1);
        check("t3_ovf_pre",  ovf, 0);
        write(32'h0001_0005);
        check("t3_ovf",      ovf, 1);
        check("t3_full2",    full, 1);
        run(170);
        check("t3_done",     n_done, DEPTH + 1);
        check("t3_rises",    n_rise, DEPTH + 1);
        check("t3_empty",    empty, 1);
        check("t3_ovf_hold", ovf, 1);

        // period=1 clamps to 3: 2 high, 1 low
        clear_mon();
        write(32'h0002_0001);
        run(12);
        check("t4_rises", n_rise, 2);
        check("t4_gap",   rise_t[1] - rise_t[0], 3);
        check("t4_high",  n_high, 4);
        check("t4_done",  n_done, 1);

        // Abort during HIGH with two queued; the concurrent write is discarded
        clear_mon();
        write(32'h0005_0014);
        write(32'h0001_0005);
        write(32'h0001_0005);
        check("t5_pre_step",  step, 1);
        check("t5_pre_empty", empty, 0);
        wr_en = 1'b1;
        wr_data = 32'h0001_0005;
        abort = 1'b1;
        tick();
        wr_en = 1'b0;
        abort = 1'b0;
        check("t5_step",  step, 0);
        check("t5_busy",  busy, 0);
        check("t5_empty", empty, 1);
        check("t5_done",  done, 0);
        clear_mon();
        run(30);
        check("t5_no_done",  n_done, 0);
        check("t5_no_rise",  n_rise, 0);
        check("t5_ovf_hold", ovf, 1);

        // Asynchronous reset between edges while in LOW
        clear_mon();
        write(32'h8003_000A);
        run(6);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_step", step, 0);
        check("t6_pre_dir",  dir, 1);
        #2;
        clr_n = 1'b0;
        #1;
        check("t6_step",  step, 0);
        check("t6_dir",   dir, 0);
        check("t6_busy",  busy, 0);
        check("t6_done",  done, 0);
        check("t6_ovf",   ovf, 0);
        check("t6_empty", empty, 1);
        check("t6_full",  full, 0);
        @(negedge clk);
        clr_n = 1'b1;
        clear_mon();
        run(20);
        check("t6_after_rise", n_rise, 0);
        check("t6_after_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_cmd_player.md
STEPPER_CMD_PLAYER -- requirements
Module: stepper_cmd_player

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PULSE_HI, default 2, meaning step-high width in clk cycles (>=1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  processor command write strobe, sampled each rising edge.
REQ-006 wr_data  input  32  command: [31] dir, [30:16] step count (15b), [15:0] period in cycles.
REQ-007 abort  input  1  flush the FIFO and stop the current move.
REQ-008 step  output  1  stepper step pulse.
REQ-009 dir  output  1  stepper direction.
REQ-010 busy  output  1  high while a command is executing.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 empty  output  1  FIFO holds 0 entries.
REQ-013 done  output  1  one-cycle pulse when a command completes.
REQ-014 ovf  output  1  sticky flag: a write was dropped because the FIFO was full.

Function
REQ-015 Writes SHALL enqueue wr_data when wr_en=1 and full=0; when full=1 the write is dropped and ovf is set.
REQ-016 The FSM SHALL have states IDLE, LOAD, HIGH, LOW.
REQ-017 IDLE: when empty=0, pop the head entry and go to LOAD next cycle; otherwise stay.
REQ-018 LOAD: latch dir, count, and effective period = max(period, PULSE_HI+1); if count=0, pulse done and return to IDLE; otherwise go to HIGH.
REQ-019 HIGH: step=1 for exactly PULSE_HI cycles, then LOW.
REQ-020 LOW: step=0 for (effective period - PULSE_HI) cycles; then decrement count; if count reaches 0, pulse done and go to IDLE; otherwise go to HIGH.
REQ-021 dir SHALL change only in LOAD and SHALL hold between commands.
REQ-022 busy SHALL be 1 in LOAD, HIGH, and LOW.
REQ-023 A write and a pop in the same cycle SHALL both take effect; occupancy is unchanged; a write while full with a simultaneous pop SHALL be accepted.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; occupancy is tracked with a log2(DEPTH)+1 bit counter.
REQ-025 abort=1 SHALL, on the next edge, empty the FIFO, force IDLE, drive step=0, and not pulse done; a write in the same cycle is discarded.
REQ-026 ovf SHALL clear only on reset.

Reset
REQ-027 clr_n=0 SHALL immediately, without a clock, force IDLE, empty FIFO with pointers 0, step=0, dir=0, busy=0, done=0, and ovf=0.
REQ-028 After reset, full=0 and empty=1; reset mid-move SHALL truncate the pulse immediately.
REQ-029 FIFO data storage SHALL need no reset.

Structure
REQ-030 A shared package SHALL hold the command field bit positions, FSM state encoding, and PULSE_HI default.
REQ-031 The FIFO SHALL be a sub-module cmd_fifo (push/pop/full/empty/count) instantiated once; the FSM and pulse counters live in the top module.

Verification
REQ-032 Write 0x8003_000A from reset -> dir=1; three step pulses, each 2 cycles high, 10 cycles apart; one done pulse; busy low afterward.
REQ-033 Write 0x0000_0005 (count=0) -> no step pulse, done pulses once, dir=0.
REQ-034 Write DEPTH+1 commands with count=1 while idle-blocked -> full=1 after DEPTH writes, ovf=1, exactly DEPTH done pulses.
REQ-035 Write period=1, count=2 -> period clamped to 3: step high 2 cycles, low 1 cycle.
REQ-036 Assert abort mid-HIGH with 2 commands queued -> next cycle step=0, busy=0, empty=1, no done pulse.
REQ-037 Drop clr_n between clock edges during LOW -> all outputs reach reset values before the next edge.
